// File: rtl/bot_if_pkg.sv
// Shared types and constants for the RojoBot interrupt sequencer.
// State encoding, counter width default and 100 MHz cycle constants.
package bot_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int CNT_W_DEF    = 8;
  localparam int HOLDOFF_DEF  = 2;
  localparam int CLK_HZ       = 100_000_000;
  localparam int TIMEOUT_10MS = CLK_HZ / 100;

endpackage

// File: rtl/intr_timer.sv
// Down-counter with load and terminal count (tc = count is zero).
// Ports: clk, reset (sync, active-low), load/load_val, dec, tc.
module intr_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/bot_intr_ctl.sv
// RojoBot update -> KCPSM6 interrupt sequencer with holdoff, watchdog
// (BOT_INTR_TIMEOUT_EN) and status counters. Ports: clk, reset (sync,
// active-low), upd_sysregs, intr_mask, clear_status, interrupt,
// interrupt_ack, pending, intr_count, ovr_count, timeout_flag.
module bot_intr_ctl
  import bot_if_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_10MS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_sysregs,
  input  logic             intr_mask,
  input  logic             clear_status,
  output logic             interrupt,
  input  logic             interrupt_ack,
  output logic             pending,
  output logic [CNT_W-1:0] intr_count,
  output logic [CNT_W-1:0] ovr_count,
  output logic             timeout_flag
);

  localparam int HOLD_N =
    (HOLDOFF_CYCLES < 1) ? 1 : HOLDOFF_CYCLES;
`ifdef BOT_INTR_TIMEOUT_EN
  localparam int WD_N =
    (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int TMR_MAX =
    (WD_N > HOLD_N) ? WD_N : HOLD_N;
`else
  localparam int TMR_MAX = HOLD_N;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  // Timer is loaded with N-1 so tc fires in the N-th cycle.
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_N - 1);
`ifdef BOT_INTR_TIMEOUT_EN
  localparam logic [TMR_W-1:0] WD_LD = TMR_W'(WD_N - 1);
`endif

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   ic_q, ic_d;
  logic [CNT_W-1:0]   oc_q, oc_d;
  logic               launch;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_dec;
  logic               tmr_tc;
`ifdef BOT_INTR_TIMEOUT_EN
  logic               to_q, to_d;
`endif

  intr_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ic_d     = ic_q;
    oc_d     = oc_q;
    launch   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;
    tmr_dec  = 1'b0;
`ifdef BOT_INTR_TIMEOUT_EN
    to_d     = to_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q && !intr_mask) begin
          launch  = 1'b1;
          state_d = ST_REQ;
`ifdef BOT_INTR_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = WD_LD;
`endif
        end
      end
      ST_REQ: begin
        // Ack beats a same-cycle watchdog expiry.
        if (interrupt_ack) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          ic_d     = ic_q + 1'b1;
`ifdef BOT_INTR_TIMEOUT_EN
        end else if (tmr_tc) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          to_d     = 1'b1;
        end else begin
          tmr_dec  = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        if (tmr_tc) state_d = ST_IDLE;
        else        tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new event is only lost when one is already waiting and
    // is not being moved into flight this cycle.
    if (upd_sysregs && pend_q && !launch && (oc_q != '1)) begin
      oc_d = oc_q + 1'b1;
    end
    if (launch)      pend_d = 1'b0;
    if (upd_sysregs) pend_d = 1'b1;

    if (clear_status) begin
      ic_d = '0;
      oc_d = '0;
`ifdef BOT_INTR_TIMEOUT_EN
      to_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      ic_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
    end
  end

`ifdef BOT_INTR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) to_q <= 1'b0;
    else        to_q <= to_d;
  end
  assign timeout_flag = to_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign interrupt  = (state_q == ST_REQ);
  assign pending    = pend_q;
  assign intr_count = ic_q;
  assign ovr_count  = oc_q;

endmodule
